ahb_burst_arbiter: RTL and testbench
====================================

// Module: ahb_burst_arbiter
// PURPOSE
//  Shares the single AHB subordinate-side bus among NUM_MGR managers.
//  Grants one manager at a time and holds the grant for a whole burst.
//  Counts accepted beats (HREADY) and hands off only at burst end.
//  Selection is fixed-priority (LSB highest) or rotating round-robin.
//  Sits between the manager ports and the address/data mux; Grant drives the mux selects.
// PARAMETERS
//  NUM_MGR      4  number of managers; >=2
//  BEATW        4  width of burst-length field; max burst = 2**BEATW beats
//  ROUND_ROBIN  0  0 = fixed priority, LSB highest; 1 = rotating priority
// PORTS
//  HCLK       in   1              bus clock; all state on rising edge
//  HRESET     in   1              synchronous, active-high reset
//  Req        in   NUM_MGR        per-manager bus request, level
//  ReqBeats   in   NUM_MGR*BEATW  per-manager burst length minus 1; slice i = [i*BEATW +: BEATW]
//  HREADY     in   1              subordinate ready; beat accepted when GrantValid & HREADY
//  Grant      out  NUM_MGR        one-hot owner, registered
//  GrantValid out  1              |Grant, registered
//  Owner      out  $clog2(NUM_MGR) binary index of owner; 0 when idle
//  BeatsLeft  out  BEATW          beats remaining after the current one
//  Done       out  1              combinational; final beat accepted this cycle
// BEHAVIOUR
//  - Reset: FSM=IDLE, Grant=0, GrantValid=0, Owner=0, BeatsLeft=0, RR pointer=0, Done=0.
//  - Reset dominates every other event; a burst in progress is abandoned with no Done.
//  - FSM states: IDLE, BUSY.
//  - IDLE, Req==0: stay in IDLE.
//  - IDLE, Req!=0: compute the winner W this cycle.
//    - Next edge: Grant=onehot(W), Owner=W, BeatsLeft=ReqBeats[W], go to BUSY.
//    - Latency from Req to Grant is 1 cycle.
//  - BUSY, HREADY=0: hold all state (stall).
//  - BUSY, HREADY=1, BeatsLeft>0: decrement BeatsLeft by 1 and keep the grant.
//  - BUSY, HREADY=1, BeatsLeft==0: Done=1 this cycle. At the next edge:
//    - if Req!=0: grant the new winner immediately (back-to-back, no idle cycle) and reload BeatsLeft.
//    - else: go to IDLE and clear Grant.
//  - Req and ReqBeats are sampled only at arbitration points (IDLE, or the Done cycle).
//    - Deasserting Req mid-burst does not release the grant.
//    - Changing ReqBeats mid-burst has no effect.
//  - Fixed mode: the winner is the lowest set index of Req. The same manager may win repeatedly.
//  - RR mode: the highest priority goes to the lowest set index strictly above the pointer, wrapping.
//    - Implement as a masked request plus a fallback on unmasked Req, each through an LSB-first priority pick.
//    - The pointer updates to W on every grant. After reset the pointer is 0, so index 1 has top priority.
//  - ReqBeats==0 gives a single-beat transfer: Done on the first HREADY.
//  - ReqBeats all-ones gives 2**BEATW beats. The counter never wraps below 0.
//  - Grant is always one-hot or zero. GrantValid==|Grant.
//  - Done is never asserted while GrantValid==0.
// TESTING
//  - Fixed mode, Req=4'b1010, ReqBeats[1]=2, HREADY=1
//    -> Grant=4'b0010 at t+1; BeatsLeft 2,1,0; Done at t+3; IDLE at t+4 if Req=0.
//  - Stall: a 4-beat burst with HREADY low for 3 cycles mid-burst
//    -> BeatsLeft frozen during the stall; Done after exactly 4 HREADY-high cycles.
//  - Back-to-back: Req=4'b0011 held, ReqBeats=0 for all, fixed mode
//    -> Grant 0001 every cycle. In RR mode: 0010, 0001, 0010, ... with no gap cycles.
//  - RR fairness: Req=4'b1111 held, single beats
//    -> Owner sequence 1,2,3,0,1 after reset.
//  - Req drop: manager 2 deasserts Req after the first beat of an 8-beat burst
//    -> Grant stays 4'b0100 until Done on beat 8.
//  - Reset mid-burst: HRESET=1 with BeatsLeft=5
//    -> next edge Grant=0, BeatsLeft=0, no Done; arbitration restarts normally after release.

Source files
------------

// File: rtl/ahb_burst_arbiter.sv
// Burst-aware AHB bus arbiter: grants one manager for a whole burst and
// re-arbitrates only when the final beat is accepted (fixed or round-robin priority).
module ahb_burst_arbiter #(
   parameter int NUM_MGR     = 4,
   parameter int BEATW       = 4,
   parameter int ROUND_ROBIN = 0
) (
   input  logic                       HCLK,
   input  logic                       HRESET,
   input  logic [NUM_MGR-1:0]         Req,
   input  logic [NUM_MGR*BEATW-1:0]   ReqBeats,
   input  logic                       HREADY,
   output logic [NUM_MGR-1:0]         Grant,
   output logic                       GrantValid,
   output logic [$clog2(NUM_MGR)-1:0] Owner,
   output logic [BEATW-1:0]           BeatsLeft,
   output logic                       Done
);

   localparam int OWNW = $clog2(NUM_MGR);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t stateReg, stateNext;

   logic [OWNW-1:0]    rrPtr, ptrNext, ownerNext, winIdx;
   logic [NUM_MGR-1:0] grantNext, rrMask, maskedReq, pickSrc;
   logic [BEATW-1:0]   beatsNext;
   logic               lastBeat, arbitrate;

   // Winner selection: in round-robin mode, requests strictly above the pointer
   // are tried first and the plain request vector is the wrap-around fallback.
   always_comb begin
      rrMask = '0;
      for (int i = 0; i < NUM_MGR; i++) begin
         rrMask[i] = (OWNW'(i) > rrPtr);
      end
      maskedReq = Req & rrMask;
      pickSrc = Req;
      if ((ROUND_ROBIN != 0) && (maskedReq != '0)) begin
         pickSrc = maskedReq;
      end
      winIdx = '0;
      for (int i = NUM_MGR - 1; i >= 0; i--) begin
         if (pickSrc[i]) begin
            winIdx = OWNW'(i);
         end
      end
   end

   assign lastBeat  = (stateReg == BUSY) && HREADY && (BeatsLeft == '0);
   assign arbitrate = (stateReg == IDLE) || lastBeat;
   assign Done      = lastBeat && !HRESET;

   // Next-state logic; Req and ReqBeats only matter at arbitration points.
   always_comb begin
      stateNext = stateReg;
      grantNext = Grant;
      ownerNext = Owner;
      beatsNext = BeatsLeft;
      ptrNext   = rrPtr;
      if (arbitrate) begin
         if (Req != '0) begin
            stateNext         = BUSY;
            grantNext         = '0;
            grantNext[winIdx] = 1'b1;
            ownerNext         = winIdx;
            beatsNext         = ReqBeats[winIdx*BEATW +: BEATW];
            ptrNext           = winIdx;
         end else begin
            stateNext = IDLE;
            grantNext = '0;
            ownerNext = '0;
            beatsNext = '0;
         end
      end else if ((stateReg == BUSY) && HREADY) begin
         beatsNext = BeatsLeft - BEATW'(1);
      end
   end

   // State register with synchronous reset abandoning any burst in progress.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         stateReg   <= IDLE;
         Grant      <= '0;
         GrantValid <= 1'b0;
         Owner      <= '0;
         BeatsLeft  <= '0;
         rrPtr      <= '0;
      end else begin
         stateReg   <= stateNext;
         Grant      <= grantNext;
         GrantValid <= |grantNext;
         Owner      <= ownerNext;
         BeatsLeft  <= beatsNext;
         rrPtr      <= ptrNext;
      end
   end

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Self-checking bench: a fixed-priority and a round-robin arbiter share stimulus
// and are compared every cycle against a burst-level reference model.
module tb_ahb_burst_arbiter;

   localparam int N  = 4;
   localparam int BW = 4;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b1;
   logic [N-1:0]  Req = '0;
   logic [N*BW-1:0] ReqBeats = '0;
   logic          HREADY = 1'b0;

   logic [N-1:0]  grantF, grantR;
   logic          validF, validR, doneF, doneR;
   logic [1:0]    ownerF, ownerR;
   logic [BW-1:0] leftF, leftR;

   int checks = 0;
   int failures = 0;

   bit mBusy [2];
   int mOwner [2];
   int mRem [2];
   int mPtr [2];

   logic lastDoneF, lastDoneR;

   typedef struct {
      bit          rst;
      logic [3:0]  req;
      logic [15:0] beats;
      bit          hready;
      bit          expDone;
      logic [3:0]  expGrant;
      logic [3:0]  expLeft;
   } vec_t;

   vec_t vecs [6];

   ahb_burst_arbiter #(.NUM_MGR(N), .BEATW(BW), .ROUND_ROBIN(0)) dutFix (
      .HCLK(HCLK), .HRESET(HRESET), .Req(Req), .ReqBeats(ReqBeats), .HREADY(HREADY),
      .Grant(grantF), .GrantValid(validF), .Owner(ownerF), .BeatsLeft(leftF), .Done(doneF)
   );

   ahb_burst_arbiter #(.NUM_MGR(N), .BEATW(BW), .ROUND_ROBIN(1)) dutRr (
      .HCLK(HCLK), .HRESET(HRESET), .Req(Req), .ReqBeats(ReqBeats), .HREADY(HREADY),
      .Grant(grantR), .GrantValid(validR), .Owner(ownerR), .BeatsLeft(leftR), .Done(doneR)
   );

   always #5 HCLK = ~HCLK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Fixed mode takes the lowest requester; rotating mode scans upward from the pointer.
   function automatic int pickWinner(input int mode, input logic [3:0] req, input int ptr);
      if (mode == 0) begin
         for (int i = 0; i < N; i++) if (req[i]) return i;
      end else begin
         for (int k = 1; k <= N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   task automatic modelStep(input int m, input bit rst, input logic [3:0] req,
                            input logic [15:0] beats, input bit hready);
      int w;
      if (rst) begin
         mBusy[m] = 0; mOwner[m] = 0; mRem[m] = 0; mPtr[m] = 0;
      end else if (!mBusy[m] || (hready && mRem[m] == 1)) begin
         if (req != 0) begin
            w = pickWinner(m, req, mPtr[m]);
            mBusy[m] = 1; mOwner[m] = w; mPtr[m] = w;
            mRem[m] = int'((beats >> (w * BW)) & 16'hF) + 1;
         end else begin
            mBusy[m] = 0; mOwner[m] = 0; mRem[m] = 0;
         end
      end else if (hready) begin
         mRem[m] = mRem[m] - 1;
      end
   endtask

   task automatic applyStimulus(input bit rst, input logic [3:0] req,
                                input logic [15:0] beats, input bit hready);
      bit expDone [2];
      @(negedge HCLK);
      HRESET = rst; Req = req; ReqBeats = beats; HREADY = hready;
      #1;
      for (int m = 0; m < 2; m++) expDone[m] = !rst && mBusy[m] && hready && (mRem[m] == 1);
      lastDoneF = doneF;
      lastDoneR = doneR;
      checkOutput("fix.Done", 32'(doneF), 32'(expDone[0]));
      checkOutput("rr.Done", 32'(doneR), 32'(expDone[1]));
      @(posedge HCLK);
      for (int m = 0; m < 2; m++) modelStep(m, rst, req, beats, hready);
      #1;
      checkOutput("fix.Grant", 32'(grantF), mBusy[0] ? 32'(1) << mOwner[0] : 32'd0);
      checkOutput("fix.GrantValid", 32'(validF), 32'(mBusy[0]));
      checkOutput("fix.Owner", 32'(ownerF), mBusy[0] ? 32'(mOwner[0]) : 32'd0);
      checkOutput("fix.BeatsLeft", 32'(leftF), mBusy[0] ? 32'(mRem[0] - 1) : 32'd0);
      checkOutput("rr.Grant", 32'(grantR), mBusy[1] ? 32'(1) << mOwner[1] : 32'd0);
      checkOutput("rr.GrantValid", 32'(validR), 32'(mBusy[1]));
      checkOutput("rr.Owner", 32'(ownerR), mBusy[1] ? 32'(mOwner[1]) : 32'd0);
      checkOutput("rr.BeatsLeft", 32'(leftR), mBusy[1] ? 32'(mRem[1] - 1) : 32'd0);
   endtask

   initial begin
      int rrSeq [5];
      for (int m = 0; m < 2; m++) begin
         mBusy[m] = 0; mOwner[m] = 0; mRem[m] = 0; mPtr[m] = 0;
      end

      // Three-beat burst for manager 1, then release to idle
      vecs[0] = '{1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 4'd0};
      vecs[1] = '{1'b0, 4'b1010, 16'h0020, 1'b1, 1'b0, 4'b0010, 4'd2};
      vecs[2] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0010, 4'd1};
      vecs[3] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0010, 4'd0};
      vecs[4] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 4'b0000, 4'd0};
      vecs[5] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 4'd0};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].beats, vecs[i].hready);
         checkOutput("vec.Done", 32'(lastDoneF), 32'(vecs[i].expDone));
         checkOutput("vec.Grant", 32'(grantF), 32'(vecs[i].expGrant));
         checkOutput("vec.BeatsLeft", 32'(leftF), 32'(vecs[i].expLeft));
      end

      // Stall: four-beat burst with three wait states after the first beat
      applyStimulus(1, 4'b0000, 16'h0000, 1);
      applyStimulus(0, 4'b0001, 16'h0003, 1);
      applyStimulus(0, 4'b0000, 16'h0000, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 4'b0000, 16'h0000, 0);
         checkOutput("stall.BeatsLeft", 32'(leftF), 32'd2);
      end
      applyStimulus(0, 4'b0000, 16'h0000, 1);
      checkOutput("stall.earlyDone", 32'(lastDoneF), 32'd0);
      applyStimulus(0, 4'b0000, 16'h0000, 1);
      checkOutput("stall.earlyDone", 32'(lastDoneF), 32'd0);
      applyStimulus(0, 4'b0000, 16'h0000, 1);
      checkOutput("stall.Done", 32'(lastDoneF), 32'd1);

      // Back-to-back single beats, then round-robin fairness over all four
      applyStimulus(1, 4'b0000, 16'h0000, 1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 4'b0011, 16'h0000, 1);
         checkOutput("b2b.fixGrant", 32'(grantF), 32'd1);
         checkOutput("b2b.rrGrant", 32'(grantR), (i % 2 == 0) ? 32'd2 : 32'd1);
      end
      applyStimulus(1, 4'b0000, 16'h0000, 1);
      rrSeq = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 4'b1111, 16'h0000, 1);
         checkOutput("fair.rrOwner", 32'(ownerR), 32'(rrSeq[i]));
      end

      // Manager 2 drops Req after the first beat of an eight-beat burst
      applyStimulus(1, 4'b0000, 16'h0000, 1);
      applyStimulus(0, 4'b0100, 16'h0700, 1);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(0, (k == 0) ? 4'b0100 : 4'b0000, 16'h0000, 1);
         checkOutput("drop.Done", 32'(lastDoneF), (k == 7) ? 32'd1 : 32'd0);
         if (k < 7) checkOutput("drop.Grant", 32'(grantF), 32'd4);
      end

      // Reset in the middle of a burst, then normal arbitration afterwards
      applyStimulus(1, 4'b0000, 16'h0000, 1);
      applyStimulus(0, 4'b0001, 16'h0006, 1);
      applyStimulus(0, 4'b0000, 16'h0000, 1);
      checkOutput("rst.preLeft", 32'(leftF), 32'd5);
      applyStimulus(1, 4'b0001, 16'h0000, 1);
      checkOutput("rst.Done", 32'(lastDoneF), 32'd0);
      checkOutput("rst.Grant", 32'(grantF), 32'd0);
      checkOutput("rst.BeatsLeft", 32'(leftF), 32'd0);
      applyStimulus(0, 4'b1000, 16'h2000, 1);
      checkOutput("rst.regrant", 32'(grantF), 32'd8);
      checkOutput("rst.regrantLeft", 32'(leftF), 32'd2);

      // Randomized traffic against the reference model, including maximum-length bursts
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 63) == 0),
                       ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom()),
                       16'($urandom()),
                       ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
